apb_controller_fsm: RTL and testbench

- Downstream neighbour of the AHB slave interface in the AHB-to-APB bridge.
- Consumes its pipelined address, data and write registers plus the valid and tempselx strobes.
- Drives the APB master-side signals (PSEL/PENABLE/PWRITE/PADDR/PWDATA) with SETUP→ENABLE sequencing.
- Drives hreadyout back to AHB to stall the master while an APB transfer is in flight.

---
 rtl/bridge_pkg.sv | 36 +++
 rtl/apb_controller_fsm.sv | 153 +++++++++++++++
 tb/tb_apb_controller_fsm.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: controller state
// encoding, slave address map and default bus widths.
package bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int NSEL_DEF   = 3;

    // APB slave region map; each region is 64 MiB.
    localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
    localparam logic [31:0] SLV_LIMIT = 32'h8C00_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_e;

    // APB SETUP phase: PSEL asserted, PENABLE low.
    function automatic logic is_setup(input apb_state_e s);
        return (s == ST_READ) || (s == ST_WRITE) || (s == ST_WRITEP);
    endfunction

    // APB ACCESS phase: PSEL and PENABLE both asserted.
    function automatic logic is_enable(input apb_state_e s);
        return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
    endfunction

endpackage

// File: rtl/apb_controller_fsm.sv
// APB master-side sequencer of the AHB-to-APB bridge: turns qualified AHB
// transfers into APB SETUP/ENABLE pairs and stalls AHB via hreadyout.
module apb_controller_fsm
    import bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSEL   = NSEL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwritereg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata1,
    input  logic [NSEL-1:0]   tempselx,
    output logic [NSEL-1:0]   pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout
);

    apb_state_e        state_q,     state_d;
    logic [NSEL-1:0]   pselx_q,     pselx_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              hreadyout_q, hreadyout_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives state_d; no latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (valid && !hwrite)     state_d = ST_READ;
                else if (valid && hwrite) state_d = ST_WWAIT;
                else                      state_d = ST_IDLE;
            end
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_RENABLE,
            ST_WENABLE: begin
                if (valid && !hwrite)     state_d = ST_READ;
                else if (valid && hwrite) state_d = ST_WWAIT;
                else                      state_d = ST_IDLE;
            end
            ST_WENABLEP: begin
                if (!hwritereg)           state_d = ST_READ;
                else if (valid)           state_d = ST_WRITEP;
                else                      state_d = ST_WRITE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output next-values, keyed on the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;

        unique case (state_d)
            ST_READ: begin
                paddr_d     = haddr;
                pwrite_d    = 1'b0;
                pselx_d     = tempselx;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_WRITE,
            ST_WRITEP: begin
                // A pipelined write's address/data have slid one stage further back.
                if (state_q == ST_WENABLEP) begin
                    paddr_d  = haddr2;
                    pwdata_d = hwdata1;
                end else begin
                    paddr_d  = haddr1;
                    pwdata_d = hwdata;
                end
                pwrite_d    = 1'b1;
                pselx_d     = tempselx;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_RENABLE,
            ST_WENABLE,
            ST_WENABLEP: begin
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            ST_IDLE,
            ST_WWAIT: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
            default: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers sample pre-edge values.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_controller_fsm.sv
// Directed bench for apb_controller_fsm: reset, single read/write, pipelined
// writes, write-then-read, decode miss, reset abort, plus protocol invariants.
module tb_apb_controller_fsm;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSEL   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic              hwrite = 1'b0;
    logic              hwritereg = 1'b0;
    logic [ADDR_W-1:0] haddr = '0;
    logic [ADDR_W-1:0] haddr1 = '0;
    logic [ADDR_W-1:0] haddr2 = '0;
    logic [DATA_W-1:0] hwdata = '0;
    logic [DATA_W-1:0] hwdata1 = '0;
    logic [NSEL-1:0]   tempselx = '0;
    logic [NSEL-1:0]   pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              hreadyout;

    int errors = 0;
    int checks = 0;
    logic monitor_on = 1'b0;

    always #5 clk = ~clk;

    apb_controller_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .hwrite    (hwrite),
        .hwritereg (hwritereg),
        .haddr     (haddr),
        .haddr1    (haddr1),
        .haddr2    (haddr2),
        .hwdata    (hwdata),
        .hwdata1   (hwdata1),
        .tempselx  (tempselx),
        .pselx     (pselx),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .hreadyout (hreadyout)
    );

    // Upstream AHB slave pipeline registers.
    always @(posedge clk) begin
        hwritereg <= hwrite;
        haddr1    <= haddr;
        haddr2    <= haddr1;
        hwdata1   <= hwdata;
    end

    // Protocol invariants sampled mid-cycle.
    logic [NSEL-1:0]   prev_psel = '0;
    logic [ADDR_W-1:0] prev_paddr = '0;
    logic              prev_pen = 1'b0;
    always @(negedge clk) begin
        if (monitor_on && rst_n) begin
            checks++;
            if (!$onehot0(pselx)) begin
                errors++;
                $display("FAIL inv_onehot: pselx=%b not one-hot or zero", pselx);
            end
            if (penable) begin
                checks++;
                if (prev_pen !== 1'b0 || prev_psel !== pselx || prev_paddr !== paddr) begin
                    errors++;
                    $display("FAIL inv_enable: prev pen=%b psel=%b paddr=%h now psel=%b paddr=%h",
                             prev_pen, prev_psel, prev_paddr, pselx, paddr);
                end
            end
        end
        prev_psel  = pselx;
        prev_paddr = paddr;
        prev_pen   = penable;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [NSEL-1:0] s);
        valid    = v;
        hwrite   = w;
        haddr    = a;
        hwdata   = d;
        tempselx = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b001);
        step();
        step();
        checks++;
        if ({pselx, penable, pwrite, hreadyout} !== {3'b000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_ctrl: got psel=%b pen=%b pwr=%b hrdy=%b want 000 0 0 1",
                     pselx, penable, pwrite, hreadyout);
        end
        checks++;
        if (paddr !== 32'h0 || pwdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_bus: got paddr=%h pwdata=%h want 0 0", paddr, pwdata);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        rst_n = 1'b1;
        step();
        checks++;
        if (pselx !== 3'b000 || hreadyout !== 1'b1 || penable !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: got psel=%b hrdy=%b pen=%b want 000 1 0",
                     pselx, hreadyout, penable);
        end
        monitor_on = 1'b1;
    endtask

    task automatic test_single_read();
        drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b001);
        step();
        checks++;
        if ({pselx, pwrite, penable, hreadyout} !== {3'b001, 1'b0, 1'b0, 1'b0} || paddr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL rd_setup: got psel=%b pwr=%b pen=%b hrdy=%b paddr=%h want 001 0 0 0 80000010",
                     pselx, pwrite, penable, hreadyout, paddr);
        end
        valid = 1'b0;
        step();
        checks++;
        if (penable !== 1'b1 || hreadyout !== 1'b1 || pselx !== 3'b001) begin
            errors++;
            $display("FAIL rd_enable: got pen=%b hrdy=%b psel=%b want 1 1 001", penable, hreadyout, pselx);
        end
        step();
        checks++;
        if (pselx !== 3'b000 || penable !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle: got psel=%b pen=%b want 000 0", pselx, penable);
        end
    endtask

    task automatic test_single_write();
        drive(1'b1, 1'b1, 32'h8400_0020, 32'h0, 3'b010);
        step();
        checks++;
        if (pselx !== 3'b000 || hreadyout !== 1'b1 || penable !== 1'b0) begin
            errors++;
            $display("FAIL wr_wwait: got psel=%b hrdy=%b pen=%b want 000 1 0", pselx, hreadyout, penable);
        end
        drive(1'b0, 1'b1, 32'h8400_0020, 32'hDEAD_BEEF, 3'b010);
        step();
        checks++;
        if (paddr !== 32'h8400_0020 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1 ||
            pselx !== 3'b010 || penable !== 1'b0 || hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL wr_setup: got paddr=%h pwdata=%h pwr=%b psel=%b pen=%b hrdy=%b want 84000020 deadbeef 1 010 0 0",
                     paddr, pwdata, pwrite, pselx, penable, hreadyout);
        end
        step();
        checks++;
        if (penable !== 1'b1 || hreadyout !== 1'b1 || paddr !== 32'h8400_0020) begin
            errors++;
            $display("FAIL wr_enable: got pen=%b hrdy=%b paddr=%h want 1 1 84000020", penable, hreadyout, paddr);
        end
        step();
        checks++;
        if (pselx !== 3'b000 || pwdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_idle: got psel=%b pwdata=%h want 000 deadbeef (held)", pselx, pwdata);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 32'h8800_0000, 32'h0, 3'b100);
        step();
        drive(1'b1, 1'b1, 32'h8800_0004, 32'h11, 3'b100);
        step();
        checks++;
        if (paddr !== 32'h8800_0000 || pwdata !== 32'h11 || pselx !== 3'b100 || penable !== 1'b0 || pwrite !== 1'b1) begin
            errors++;
            $display("FAIL b2b_setup1: got paddr=%h pwdata=%h psel=%b pen=%b pwr=%b want 88000000 11 100 0 1",
                     paddr, pwdata, pselx, penable, pwrite);
        end
        drive(1'b0, 1'b1, 32'h8800_0004, 32'h22, 3'b100);
        step();
        checks++;
        if (penable !== 1'b1 || paddr !== 32'h8800_0000 || pselx !== 3'b100) begin
            errors++;
            $display("FAIL b2b_enable1: got pen=%b paddr=%h psel=%b want 1 88000000 100", penable, paddr, pselx);
        end
        step();
        checks++;
        if (paddr !== 32'h8800_0004 || pwdata !== 32'h22 || pselx !== 3'b100 || penable !== 1'b0 ||
            pwrite !== 1'b1 || hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_setup2: got paddr=%h pwdata=%h psel=%b pen=%b pwr=%b hrdy=%b want 88000004 22 100 0 1 0",
                     paddr, pwdata, pselx, penable, pwrite, hreadyout);
        end
        step();
        checks++;
        if (penable !== 1'b1 || paddr !== 32'h8800_0004 || pwdata !== 32'h22) begin
            errors++;
            $display("FAIL b2b_enable2: got pen=%b paddr=%h pwdata=%h want 1 88000004 22", penable, paddr, pwdata);
        end
        step();
        checks++;
        if (pselx !== 3'b000 || penable !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got psel=%b pen=%b want 000 0", pselx, penable);
        end
    endtask

    task automatic test_write_then_read();
        drive(1'b1, 1'b1, 32'h8000_0000, 32'h0, 3'b001);
        step();
        drive(1'b1, 1'b0, 32'h8000_0008, 32'h33, 3'b001);
        step();
        checks++;
        if (paddr !== 32'h8000_0000 || pwdata !== 32'h33 || pwrite !== 1'b1 || pselx !== 3'b001) begin
            errors++;
            $display("FAIL wtr_wsetup: got paddr=%h pwdata=%h pwr=%b psel=%b want 80000000 33 1 001",
                     paddr, pwdata, pwrite, pselx);
        end
        valid = 1'b0;
        step();
        checks++;
        if (penable !== 1'b1 || pwrite !== 1'b1) begin
            errors++;
            $display("FAIL wtr_wenable: got pen=%b pwr=%b want 1 1", penable, pwrite);
        end
        step();
        checks++;
        if (paddr !== 32'h8000_0008 || pwrite !== 1'b0 || penable !== 1'b0 || pselx !== 3'b001 || hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL wtr_rsetup: got paddr=%h pwr=%b pen=%b psel=%b hrdy=%b want 80000008 0 0 001 0",
                     paddr, pwrite, penable, pselx, hreadyout);
        end
        step();
        checks++;
        if (penable !== 1'b1 || paddr !== 32'h8000_0008) begin
            errors++;
            $display("FAIL wtr_renable: got pen=%b paddr=%h want 1 80000008", penable, paddr);
        end
        step();
        checks++;
        if (pselx !== 3'b000 || hreadyout !== 1'b1) begin
            errors++;
            $display("FAIL wtr_idle: got psel=%b hrdy=%b want 000 1", pselx, hreadyout);
        end
    endtask

    task automatic test_decode_miss();
        drive(1'b1, 1'b0, 32'h8C00_0000, 32'h0, 3'b000);
        step();
        checks++;
        if (pselx !== 3'b000 || hreadyout !== 1'b0 || paddr !== 32'h8C00_0000) begin
            errors++;
            $display("FAIL miss_setup: got psel=%b hrdy=%b paddr=%h want 000 0 8c000000", pselx, hreadyout, paddr);
        end
        valid = 1'b0;
        step();
        checks++;
        if (penable !== 1'b1 || pselx !== 3'b000) begin
            errors++;
            $display("FAIL miss_enable: got pen=%b psel=%b want 1 000", penable, pselx);
        end
        step();
    endtask

    task automatic test_reset_mid_transfer();
        drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b001);
        step();
        checks++;
        if (pselx !== 3'b001 || hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL mrst_setup: got psel=%b hrdy=%b want 001 0", pselx, hreadyout);
        end
        valid = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if (penable !== 1'b0 || pselx !== 3'b000 || hreadyout !== 1'b1 || paddr !== 32'h0) begin
            errors++;
            $display("FAIL mrst_abort: got pen=%b psel=%b hrdy=%b paddr=%h want 0 000 1 0",
                     penable, pselx, hreadyout, paddr);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (penable !== 1'b0 || pselx !== 3'b000) begin
            errors++;
            $display("FAIL mrst_no_enable: got pen=%b psel=%b want 0 000", penable, pselx);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_write_then_read();
        test_decode_miss();
        test_reset_mid_transfer();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
